// File: rtl/frame_config_loader.sv
// frame_config_loader
// Streams configuration frames into one fabric column. A header word selects
// the frame index, NumRows data words fill the column FrameData register row
// by row, and the addressed FrameStrobe line is then pulsed so every tile's
// ConfigMem latches the assembled frame.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | waiting for a header word
//   S_LOAD    | accepting data words into FrameData rows
//   S_DISCARD | swallowing the data words of a frame with a bad index
//   S_STROBE  | FrameStrobe = one-hot(frame) for StrobeCycles cycles
//   S_GAP     | strobe low for one cycle of data hold, count the frame
module frame_config_loader #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 8,
  parameter int StrobeCycles    = 2
) (
  input  logic                                 UserCLK,
  input  logic                                 reset,
  input  logic [FrameBitsPerRow-1:0]           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 err_clr,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 err,
  output logic [15:0]                          frames_done
);

  localparam int RW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int SW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  // Header frame-index field is bits [20:16].
  localparam int FW = 5;
  localparam logic [7:0] HDR_MAGIC = 8'hFA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_STROBE,
    S_GAP
  } state_t;

  state_t                        r_state;
  logic [RW-1:0]                 r_row;
  logic [SW-1:0]                 r_scnt;
  logic [FW-1:0]                 r_frame;
  logic [MaxFramesPerCol-1:0]    r_strobe;
  logic [FrameBitsPerRow-1:0]    r_rows [NumRows];
  logic                          r_err;
  logic [15:0]                   r_frames_done;

  logic                          w_ready;
  logic                          w_xfer;
  logic                          w_hdr_magic_ok;
  logic [FW-1:0]                 w_hdr_idx;
  logic                          w_hdr_in_range;
  logic                          w_last_row;
  logic                          w_strobe_done;
  logic                          w_err_set;
  logic [MaxFramesPerCol-1:0]    w_strobe_onehot;

  // Ready is a pure decode of the state register, so s_valid never reaches
  // s_ready combinationally; reset forces it low while asserted.
  assign w_ready = (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_DISCARD);
  assign s_ready = w_ready & ~reset;
  assign w_xfer  = s_valid & w_ready;

  assign w_hdr_magic_ok  = (s_data[31:24] == HDR_MAGIC);
  assign w_hdr_idx       = s_data[20:16];
  assign w_hdr_in_range  = (int'(w_hdr_idx) < MaxFramesPerCol);
  assign w_last_row      = (r_row == RW'(NumRows - 1));
  assign w_strobe_done   = (r_scnt == SW'(StrobeCycles - 1));
  assign w_strobe_onehot = MaxFramesPerCol'(1) << r_frame;

  // Any rejected header (bad magic or index out of range) flags an error.
  assign w_err_set = (r_state == S_IDLE) && w_xfer && (!w_hdr_magic_ok || !w_hdr_in_range);

  // Frame sequencing: header decode, row/strobe counting, frame counter.
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_scnt        <= '0;
      r_frame       <= '0;
      r_strobe      <= '0;
      r_frames_done <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A wrong-magic header is consumed and dropped in place.
          if (w_xfer && w_hdr_magic_ok) begin
            r_row <= '0;
            if (w_hdr_in_range) begin
              r_frame <= w_hdr_idx;
              r_state <= S_LOAD;
            end else begin
              r_state <= S_DISCARD;
            end
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            if (w_last_row) begin
              r_scnt   <= '0;
              r_strobe <= w_strobe_onehot;
              r_state  <= S_STROBE;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end
        end
        S_DISCARD: begin
          if (w_xfer) begin
            if (w_last_row) begin
              r_state <= S_IDLE;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end
        end
        S_STROBE: begin
          if (w_strobe_done) begin
            r_strobe <= '0;
            r_state  <= S_GAP;
          end else begin
            r_scnt <= r_scnt + SW'(1);
          end
        end
        S_GAP: begin
          r_frames_done <= r_frames_done + 16'd1;
          r_state       <= S_IDLE;
        end
        default: begin
          r_strobe <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Frame data register: written only by accepted words in S_LOAD, so it
  // stays stable through the strobe window and holds the last frame.
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NumRows; k++) begin
        r_rows[k] <= '0;
      end
    end else if ((r_state == S_LOAD) && w_xfer) begin
      r_rows[r_row] <= s_data;
    end
  end

  // Sticky error: a new error wins over a simultaneous clear request.
  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  for (genvar g = 0; g < NumRows; g++) begin : g_rows
    assign FrameData[g*FrameBitsPerRow +: FrameBitsPerRow] = r_rows[g];
  end

  assign FrameStrobe = r_strobe;
  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign frames_done = r_frames_done;

endmodule
